// File: rtl/ula_controlador.sv
// Host-side command/response driver for the registered ALU (ULA_Final).
// Optional reference-model checker is built when ULA_CHECK_EN is defined.
module ula_controlador #(
  parameter int unsigned ULA_LAT = 1,
  parameter int unsigned W       = 8
) (
  input  logic         clk,
  input  logic         CLR_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] ula_A,
  output logic [W-1:0] ula_B,
  output logic [2:0]   ula_OPCODE,
  output logic         ula_EN,
  input  logic [W:0]   ula_s,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W:0]   res_data,
  output logic         res_zero,
  output logic         res_carry,
  output logic [W:0]   acc,
  output logic         busy,
  output logic         chk_err,
  output logic [7:0]   chk_cnt
);

  localparam int unsigned CW = (ULA_LAT < 2) ? 1 : $clog2(ULA_LAT + 1);
  localparam logic [CW-1:0] LAT_LD = CW'(ULA_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [2:0]    r_op;
  logic          r_en;
  logic          r_ready;
  logic          r_busy;
  logic          r_valid;
  logic [W:0]    r_res;
  logic          r_zero;
  logic          r_carry;
  logic [W:0]    r_acc;
  logic          w_capture;

  // Counter is loaded in EXEC, so it hits 1 on the last WAIT edge.
  assign w_capture = (r_state == S_WAIT) && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_en    <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a     <= cmd_use_acc ? r_acc[W-1:0] : cmd_a;
            r_b     <= cmd_b;
            r_op    <= cmd_op;
            r_en    <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt   <= LAT_LD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_capture) begin
            r_res   <= ula_s;
            r_acc   <= ula_s;
            r_zero  <= (ula_s[W-1:0] == '0);
            r_carry <= ula_s[W];
            r_valid <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_ready;
  assign ula_A      = r_a;
  assign ula_B      = r_b;
  assign ula_OPCODE = r_op;
  assign ula_EN     = r_en;
  assign res_valid  = r_valid;
  assign res_data   = r_res;
  assign res_zero   = r_zero;
  assign res_carry  = r_carry;
  assign acc        = r_acc;
  assign busy       = r_busy;

`ifdef ULA_CHECK_EN
  logic [W:0] w_exp;
  logic       w_chk;
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_comb begin
    w_exp = '0;
    w_chk = 1'b1;
    case (r_op)
      3'b000: w_exp = {1'b0, r_a} + {1'b0, r_b};
      3'b001: w_exp = {1'b0, r_a} - {1'b0, r_b};
      3'b011: w_exp = {1'b0, r_a & r_b};
      3'b100: w_exp = {1'b0, r_a | r_b};
      3'b101: w_exp = {1'b0, r_a ^ r_b};
      3'b110: w_exp = {1'b0, ~r_a};
      3'b111: w_exp = {1'b0, ~r_b};
      default: w_chk = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_capture && w_chk && (w_exp != ula_s)) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign chk_err = r_err;
  assign chk_cnt = r_err_cnt;
`else
  assign chk_err = 1'b0;
  assign chk_cnt = '0;
`endif

endmodule

// File: tb/tb_ula_controlador.sv
// Self-checking bench for ula_controlador with a behavioural one-cycle ALU.
// Under ULA_CHECK_EN the ALU can be forced to return a wrong AND result.
module tb_ula_controlador;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         CLR_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [W-1:0] ula_A;
  logic [W-1:0] ula_B;
  logic [2:0]   ula_OPCODE;
  logic         ula_EN;
  logic [W:0]   ula_s = '0;
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   res_data;
  logic         res_zero;
  logic         res_carry;
  logic [W:0]   acc;
  logic         busy;
  logic         chk_err;
  logic [7:0]   chk_cnt;
  logic         stub_zero;

  always #5 clk = ~clk;

  ula_controlador #(.ULA_LAT(1), .W(W)) dut (
    .clk(clk), .CLR_n(CLR_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .ula_A(ula_A), .ula_B(ula_B), .ula_OPCODE(ula_OPCODE), .ula_EN(ula_EN),
    .ula_s(ula_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry), .acc(acc), .busy(busy),
    .chk_err(chk_err), .chk_cnt(chk_cnt)
  );

  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    case (op)
      3'd0: alu = {1'b0, a} + {1'b0, b};
      3'd1: alu = {1'b0, a} - {1'b0, b};
      3'd2: alu = {8'd0, a < b};
      3'd3: alu = {1'b0, a & b};
      3'd4: alu = {1'b0, a | b};
      3'd5: alu = {1'b0, a ^ b};
      3'd6: alu = {1'b0, ~a};
      default: alu = {1'b0, ~b};
    endcase
  endfunction

  always @(posedge clk)
    if (ula_EN)
      ula_s <= (stub_zero && ula_OPCODE == 3'd3) ? 9'h000 : alu(ula_A, ula_B, ula_OPCODE);

  int n_pass = 0;
  int n_tot  = 0;
  logic [8:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ua, input logic [8:0] exp);
    bit ok = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) ok = 1;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    else sb.push_back(exp);
  endtask

  task automatic recv(input string name);
    bit ok = 0;
    logic [8:0] e;
    res_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk({name, "_resp_timeout"}, 0, 1);
    else if (sb.size() == 0) chk({name, "_sb_empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      chk({name, "_data"}, res_data, e);
      chk({name, "_zero"}, res_zero, e[7:0] == 8'h00);
      chk({name, "_carry"}, res_carry, e[8]);
      tick();
      chk({name, "_acc"}, acc, e);
      chk({name, "_valid_clr"}, res_valid, 0);
    end
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ua;
    logic [7:0] a_exp;
    logic [8:0] res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic [8:0] e;

    vecs[0] = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'hFF, 9'h100};
    vecs[1] = '{3'd0, 8'h28, 8'h02, 1'b0, 8'h28, 9'h02A};
    vecs[2] = '{3'd1, 8'h00, 8'h04, 1'b1, 8'h2A, 9'h026};
    vecs[3] = '{3'd3, 8'hAA, 8'hCC, 1'b0, 8'hAA, 9'h088};
    vecs[4] = '{3'd4, 8'hF0, 8'h0F, 1'b0, 8'hF0, 9'h0FF};
    vecs[5] = '{3'd5, 8'hFF, 8'h0F, 1'b0, 8'hFF, 9'h0F0};
    vecs[6] = '{3'd6, 8'h0F, 8'h33, 1'b0, 8'h0F, 9'h0F0};
    vecs[7] = '{3'd7, 8'h12, 8'h00, 1'b0, 8'h12, 9'h0FF};
    vecs[8] = '{3'd1, 8'h03, 8'h05, 1'b0, 8'h03, 9'h1FE};
    vecs[9] = '{3'd0, 8'h77, 8'h01, 1'b1, 8'hFE, 9'h0FF};

    CLR_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; res_ready = 1'b0; stub_zero = 1'b0;
    repeat (3) tick();
    CLR_n = 1'b1;
    tick();
    chk("rst_ulaA", ula_A, 0);
    chk("rst_ulaB", ula_B, 0);
    chk("rst_op", ula_OPCODE, 0);
    chk("rst_en", ula_EN, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_flags", {res_zero, res_carry}, 0);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chk", {chk_err, chk_cnt}, 0);
    chk("rst_ready", cmd_ready, 1);

    // first command: exact EN pulse and response latency
    send(3'd0, 8'h04, 8'h03, 1'b0, 9'h007);
    chk("t1_en_on", ula_EN, 1);
    chk("t1_ulaA", ula_A, 8'h04);
    chk("t1_ulaB", ula_B, 8'h03);
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", cmd_ready, 0);
    tick();
    chk("t1_en_off", ula_EN, 0);
    chk("t1_valid_early", res_valid, 0);
    chk("t1_ulaA_hold", ula_A, 8'h04);
    tick();
    chk("t1_valid_lat", res_valid, 1);
    recv("t1");

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].res);
      chk($sformatf("v%0d_ulaA", i), ula_A, vecs[i].a_exp);
      chk($sformatf("v%0d_op", i), ula_OPCODE, vecs[i].op);
      recv($sformatf("v%0d", i));
    end

    // backpressure with a second command waiting
    send(3'd0, 8'h10, 8'h20, 1'b0, 9'h030);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("bp_valid_seen", seen, 1);
    cmd_op = 3'd5; cmd_a = 8'h55; cmd_b = 8'hAA; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), res_valid, 1);
      chk($sformatf("bp_data_%0d", i), res_data, 9'h030);
      chk($sformatf("bp_ready_%0d", i), cmd_ready, 0);
      chk($sformatf("bp_ulaA_%0d", i), ula_A, 8'h10);
      tick();
    end
    res_ready = 1'b1;
    e = sb.pop_front();
    chk("bp_first_data", res_data, e);
    tick();
    res_ready = 1'b0;
    chk("bp_valid_clr", res_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);
    chk("bp_no_en_yet", ula_EN, 0);
    tick();
    cmd_valid = 1'b0;
    sb.push_back(9'h0FF);
    chk("bp_second_en", ula_EN, 1);
    chk("bp_second_ulaA", ula_A, 8'h55);
    recv("bp_second");

`ifdef ULA_CHECK_EN
    stub_zero = 1'b1;
    send(3'd3, 8'hAA, 8'hCC, 1'b0, 9'h000);
    recv("stub_and");
    stub_zero = 1'b0;
    chk("chk_err_set", chk_err, 1);
    chk("chk_cnt_one", chk_cnt, 1);
`else
    chk("chk_err_tied", chk_err, 0);
    chk("chk_cnt_tied", chk_cnt, 0);
`endif

    // reset while waiting on the ALU
    send(3'd0, 8'h11, 8'h22, 1'b0, 9'h033);
    chk("mr_busy", busy, 1);
    chk("mr_acc_nonzero", acc != 0, 1);
    CLR_n = 1'b0;
    #1;
    chk("mr_valid", res_valid, 0);
    chk("mr_en", ula_EN, 0);
    chk("mr_acc", acc, 0);
    chk("mr_busy_clr", busy, 0);
    chk("mr_ulaA", ula_A, 0);
    chk("mr_chk", {chk_err, chk_cnt}, 0);
    tick();
    CLR_n = 1'b1;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) seen = 1;
      tick();
    end
    chk("mr_no_resp", seen, 0);
    chk("mr_ready", cmd_ready, 1);

    send(3'd0, 8'h01, 8'h01, 1'b0, 9'h002);
    recv("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ula_controlador.md
Name: ula_controlador

Overview:
Host-side driver for the registered 8-bit ALU (ULA_Final). Accepts one command (opcode, operands) per valid/ready handshake and drives the ALU's A, B, OPCODE and EN inputs. Waits the ALU's fixed latency, captures the 9-bit result into an accumulator, and returns it with flags over a second valid/ready handshake. Sits between a sequencer/host and the ULA_Final instance.

Parameters:
ULA_LAT, 1, clock edges from the EN-high cycle until the ALU's s output is valid; must be >= 1.
W, 8, operand width; result width is W+1.

Ports:
clk  input  1  system clock, rising edge.
CLR_n  input  1  asynchronous reset, active low.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 compare, 011 AND, 100 OR, 101 XOR, 110 NOT A, 111 NOT B.
cmd_a  input  W  operand A.
cmd_b  input  W  operand B.
cmd_use_acc  input  1  1 = use acc[W-1:0] as A instead of cmd_a.
ula_A  output  W  to ALU A.
ula_B  output  W  to ALU B.
ula_OPCODE  output  3  to ALU OPCODE.
ula_EN  output  1  to ALU EN.
ula_s  input  W+1  ALU result s.
res_valid  output  1  result available.
res_ready  input  1  consumer takes result.
res_data  output  W+1  captured result.
res_zero  output  1  res_data[W-1:0] == 0.
res_carry  output  1  res_data[W].
acc  output  W+1  last captured result.
busy  output  1  state != IDLE.
chk_err  output  1  sticky model mismatch (see Optional Feature).
chk_cnt  output  8  mismatch count, saturating at 255.

Behaviour:
- Single clock domain. CLR_n asynchronous, active low.
- Reset state: state IDLE; ula_A/ula_B/ula_OPCODE/ula_EN/res_valid/res_data/res_zero/res_carry/acc/busy/chk_err/chk_cnt all 0.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge n: latch ula_A = cmd_use_acc ? acc[W-1:0] : cmd_a, plus ula_B and ula_OPCODE. Go to EXEC.
- EXEC: lasts exactly one cycle. ula_EN=1 in this cycle only. Load wait counter with ULA_LAT. Go to WAIT.
- WAIT: counter decrements each edge. ula_A/B/OPCODE held stable; ula_EN=0. When counter reaches 0, capture ula_s into res_data and acc, update flags, go to RESP.
- Capture edge is n+ULA_LAT+1. res_valid rises after that edge (2 cycles after accept for ULA_LAT=1).
- RESP: res_valid=1. res_data and flags held stable until res_valid&res_ready. On that edge go to IDLE and clear res_valid.
- Throughput: next command accepted at earliest edge n+ULA_LAT+3.
- cmd_ready=0 in EXEC/WAIT/RESP. cmd_valid in those states is ignored; there is no queuing.
- Accepting a command and completing a response cannot happen in the same cycle. This is by construction, not arbitration.
- acc keeps its value across commands. The use_acc operand is sampled at accept, so chaining always uses the previous result.
- ula_s is sampled only at the capture edge; changes on it at any other time have no effect.
- Reset mid-operation (any state): all outputs clear immediately and asynchronously. The in-flight result is discarded, and no res_valid follows after release.
- Width rule: results are W+1 bits and are never truncated. acc[W] is ignored when acc feeds A.

Optional Feature:
Macro ULA_CHECK_EN.
- Defined: at each capture edge, an internal reference model computes the expected result:
  - add: 9-bit A+B.
  - sub: 9-bit A-B, two's-complement wrap.
  - logic ops and NOTs: zero-extended.
  - opcode 010: not checked.
  - On mismatch, chk_err is set (sticky until reset) and chk_cnt increments, saturating at 255.
- Not defined: no model logic is built; chk_err and chk_cnt are tied to 0.

Test Plan:
- CLR_n low 3 cycles, then high -> all outputs 0, cmd_ready=1, busy=0.
- op 000, A=0x04, B=0x03 (ULA_LAT=1) -> ula_EN high exactly 1 cycle with A=0x04/B=0x03; res_valid 2 cycles after accept; res_data=0x007, zero=0, carry=0.
- op 000, A=0xFF, B=0x01 -> res_data=0x100, carry=1, zero=1, acc=0x100.
- op 000, A=0x28, B=0x02 -> 0x02A; then use_acc=1, op 001, B=0x04 -> ula_A=0x2A, res_data=0x026.
- res_ready low 5 cycles with cmd_valid high -> res_valid and res_data stable, cmd_ready=0, second command accepted only after the response handshake.
- CLR_n pulsed low during WAIT -> res_valid and ula_EN 0 at once, acc=0, no response after release. With ULA_CHECK_EN, a stub ALU returning 0x000 for op 011, A=0xAA, B=0xCC (expected 0x088) -> chk_err=1, chk_cnt=1.
